// File: rtl/qsn_len3_pkg.sv
// rtl/qsn_len3_pkg.sv - shared constants and select encoding for the length-3 QSN shifter
package qsn_len3_pkg;

  localparam int PERMUTATION_LENGTH = 3;
  localparam int SHIFT_W            = 2;

  typedef struct packed {
    logic [SHIFT_W-1:0] left;
    logic [SHIFT_W-1:0] right;
    logic [SHIFT_W-1:0] merge;
  } qsn_sel_t;

  // Undo a forward cyclic shift of s: (3 - s) mod 3.
  function automatic logic [SHIFT_W-1:0] inv_shift(input logic [SHIFT_W-1:0] s);
    case (s)
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Shift amount k to barrel selects; the forward controller uses the same encoding.
  function automatic qsn_sel_t shift_to_sel(input logic [SHIFT_W-1:0] k);
    qsn_sel_t sel;
    case (k)
      2'd1:    sel = '{left: 2'd1, right: 2'd2, merge: 2'b11};
      2'd2:    sel = '{left: 2'd2, right: 2'd1, merge: 2'b01};
      default: sel = '{left: 2'd0, right: 2'd0, merge: 2'b00};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/qsn_deperm_controller_len3_if.sv
// rtl/qsn_deperm_controller_len3_if.sv - forward/return handshake and select bus
interface qsn_deperm_controller_len3_if
  import qsn_len3_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int OCC_W     = $clog2(FIFO_DEPTH + 1)
);
  logic               fwd_valid;
  logic [SHIFT_W-1:0] fwd_shift;
  logic               fwd_ready;
  logic               ret_valid;
  logic               ret_ready;
  logic [SHIFT_W-1:0] left_sel;
  logic [SHIFT_W-1:0] right_sel;
  logic [SHIFT_W-1:0] merge_sel;
  logic               sel_valid;
  logic [OCC_W-1:0]   occupancy;
  logic               overflow_err;
  logic               underflow_err;
  logic               illegal_err;

  modport master (
    output fwd_valid, fwd_shift, ret_valid,
    input  fwd_ready, ret_ready, left_sel, right_sel, merge_sel, sel_valid,
           occupancy, overflow_err, underflow_err, illegal_err
  );

  modport slave (
    input  fwd_valid, fwd_shift, ret_valid,
    output fwd_ready, ret_ready, left_sel, right_sel, merge_sel, sel_valid,
           occupancy, overflow_err, underflow_err, illegal_err
  );
endinterface

// File: rtl/qsn_shift_fifo.sv
// rtl/qsn_shift_fifo.sv - synchronous FIFO holding outstanding shift factors
module qsn_shift_fifo #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/qsn_deperm_controller_len3.sv
// rtl/qsn_deperm_controller_len3.sv - return-path inverse-permutation select controller
module qsn_deperm_controller_len3
  import qsn_len3_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int OCC_W     = $clog2(FIFO_DEPTH + 1)
) (
  input logic sys_clk,
  input logic rstn,
  qsn_deperm_controller_len3_if.slave bus
);
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [SHIFT_W-1:0] head;
  logic [OCC_W-1:0]   count;
  qsn_sel_t           sel_q;
  logic               sel_valid_q;
  logic               ovf_q;
  logic               unf_q;
  logic               ill_q;

  // Ready flags decode registered occupancy only; no valid-to-ready path.
  assign push = bus.fwd_valid & ~full & (bus.fwd_shift != 2'd3);
  assign pop  = bus.ret_valid & ~empty;

  qsn_shift_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SHIFT_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rstn  (rstn),
    .push  (push),
    .din   (bus.fwd_shift),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      sel_valid_q <= pop;
      if (pop) begin
        sel_q <= shift_to_sel(inv_shift(head));
      end
      ovf_q <= ovf_q | (bus.fwd_valid & full);
      unf_q <= unf_q | (bus.ret_valid & empty);
      ill_q <= ill_q | (bus.fwd_valid & (bus.fwd_shift == 2'd3));
    end
  end

  assign bus.fwd_ready     = ~full;
  assign bus.ret_ready     = ~empty;
  assign bus.left_sel      = sel_q.left;
  assign bus.right_sel     = sel_q.right;
  assign bus.merge_sel     = sel_q.merge;
  assign bus.sel_valid     = sel_valid_q;
  assign bus.occupancy     = count;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
  assign bus.illegal_err   = ill_q;
endmodule

// File: tb/tb_qsn_deperm_controller_len3.sv
// tb/tb_qsn_deperm_controller_len3.sv - directed scoreboard bench for the deperm controller
module tb_qsn_deperm_controller_len3;
  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;
  always #5 sys_clk = ~sys_clk;

  qsn_deperm_controller_len3_if bus ();

  qsn_deperm_controller_len3 dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] q  [$];
  logic [5:0] sb [$];
  logic       m_sv  = 1'b0;
  logic [5:0] m_sel = '0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_ill = 1'b0;

  // {left, right, merge} that undoes a forward shift of s
  function automatic logic [5:0] exp_sel(input logic [1:0] s);
    case (s)
      2'd1:    return {2'd2, 2'd1, 2'b01};
      2'd2:    return {2'd1, 2'd2, 2'b11};
      default: return 6'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic fv, input logic [1:0] fs, input logic rv, input logic rn);
    bit full_m, empty_m;
    bus.fwd_valid = fv;
    bus.fwd_shift = fs;
    bus.ret_valid = rv;
    rstn          = rn;
    if (!rn) begin
      q.delete();
      sb.delete();
      m_sv  = 1'b0;
      m_sel = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ill = 1'b0;
    end else begin
      full_m  = (q.size() == 8);
      empty_m = (q.size() == 0);
      if (fv && full_m)   m_ovf = 1'b1;
      if (rv && empty_m)  m_unf = 1'b1;
      if (fv && fs == 3)  m_ill = 1'b1;
      m_sv = rv && !empty_m;
      if (m_sv) sb.push_back(exp_sel(q.pop_front()));
      if (fv && !full_m && fs != 3) q.push_back(fs);
    end
    @(posedge sys_clk);
    #1;
    chk("sel_valid", 32'(bus.sel_valid), 32'(m_sv));
    if (bus.sel_valid === 1'b1) begin
      chk("scoreboard_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) m_sel = sb.pop_front();
    end
    chk("left_sel",      32'(bus.left_sel),      32'(m_sel[5:4]));
    chk("right_sel",     32'(bus.right_sel),     32'(m_sel[3:2]));
    chk("merge_sel",     32'(bus.merge_sel),     32'(m_sel[1:0]));
    chk("occupancy",     32'(bus.occupancy),     32'(q.size()));
    chk("fwd_ready",     32'(bus.fwd_ready),     32'(q.size() != 8));
    chk("ret_ready",     32'(bus.ret_ready),     32'(q.size() != 0));
    chk("overflow_err",  32'(bus.overflow_err),  32'(m_ovf));
    chk("underflow_err", 32'(bus.underflow_err), 32'(m_unf));
    chk("illegal_err",   32'(bus.illegal_err),   32'(m_ill));
  endtask

  initial begin
    bus.fwd_valid = 1'b0;
    bus.fwd_shift = 2'd0;
    bus.ret_valid = 1'b0;

    // reset held for 3 cycles, then released
    repeat (3) tick(1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    chk("reset_fwd_ready", 32'(bus.fwd_ready), 32'd1);
    chk("reset_occupancy", 32'(bus.occupancy), 32'd0);

    // ordering: push 1,2,0 then pop three times
    tick(1'b1, 2'd1, 1'b0, 1'b1);
    tick(1'b1, 2'd2, 1'b0, 1'b1);
    tick(1'b1, 2'd0, 1'b0, 1'b1);
    tick(1'b0, 2'd0, 1'b1, 1'b1);
    chk("order_first_left", 32'(bus.left_sel), 32'd2);
    tick(1'b0, 2'd0, 1'b1, 1'b1);
    chk("order_second_merge", 32'(bus.merge_sel), 32'b11);
    tick(1'b0, 2'd0, 1'b1, 1'b1);
    tick(1'b0, 2'd0, 1'b0, 1'b1);

    // fill to 8, attempt a 9th, then drain in order
    for (int i = 0; i < 8; i++) tick(1'b1, 2'($urandom_range(0, 2)), 1'b0, 1'b1);
    chk("full_occupancy", 32'(bus.occupancy), 32'd8);
    tick(1'b1, 2'd1, 1'b0, 1'b1);
    chk("overflow_set", 32'(bus.overflow_err), 32'd1);
    tick(1'b1, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b0, 2'd0, 1'b1, 1'b1);
    tick(1'b0, 2'd0, 1'b0, 1'b1);

    // underflow on empty, then illegal shift value
    tick(1'b0, 2'd0, 1'b1, 1'b1);
    chk("underflow_set", 32'(bus.underflow_err), 32'd1);
    tick(1'b1, 2'd3, 1'b0, 1'b1);
    chk("illegal_set", 32'(bus.illegal_err), 32'd1);

    // simultaneous push and pop at occupancy 3, across pointer wrap
    for (int i = 0; i < 3; i++) tick(1'b1, 2'($urandom_range(0, 2)), 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) tick(1'b1, 2'($urandom_range(0, 2)), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 1'b1, 1'b1);
    tick(1'b0, 2'd0, 1'b0, 1'b1);

    // reset mid-stream with a pop pending
    for (int i = 0; i < 5; i++) tick(1'b1, 2'($urandom_range(0, 2)), 1'b0, 1'b1);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    chk("midreset_occupancy", 32'(bus.occupancy), 32'd0);
    tick(1'b1, 2'd2, 1'b0, 1'b1);
    tick(1'b0, 2'd0, 1'b1, 1'b1);
    chk("post_reset_left",  32'(bus.left_sel),  32'd1);
    chk("post_reset_right", 32'(bus.right_sel), 32'd2);
    chk("post_reset_merge", 32'(bus.merge_sel), 32'b11);
    tick(1'b0, 2'd0, 1'b0, 1'b1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
